// File: rtl/sonar_pkg.sv
// Shared definitions for the ultrasonic sensor scheduler.
// Holds the scheduler state encoding and the default parameter values
// that the scheduler and its testbench both reuse.
package sonar_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StGap
    } sonar_state_t;

    localparam int unsigned DefNSens      = 4;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefTrigCyc    = 10;
    localparam int unsigned DefTimeoutCyc = 30000;
    localparam int unsigned DefGapCyc     = 600;
    localparam int unsigned DefThrShift   = 8;

endpackage

// File: rtl/sonar_scheduler_echo_sync.sv
// echo_sync: parameterised N-bit two-flop synchronizer for the raw echo lines.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, clears both flop stages
//   din  - asynchronous input bits
//   dout - synchronized bits, two cycles after din
module echo_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin measurement controller for an ultrasonic sensor array.
// Fires one sensor at a time, times its echo pulse with a timeout, reports the
// distance and keeps sticky per-sensor obstacle / no-echo flags.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   ena        - run enable, only looked at while idle
//   thresh     - obstacle threshold, effective value is thresh << THR_SHIFT
//   echo       - raw asynchronous echo lines, one per sensor
//   trig       - registered trigger outputs, at most one bit high
//   sel        - sensor currently owned by the scheduler
//   dist_out   - last captured distance in cycles of echo high
//   dist_id    - sensor index belonging to dist_out
//   dist_valid - one-cycle pulse when dist_out / dist_id update
//   obstacle   - per-sensor obstacle flags, sticky until re-measured
//   fault      - per-sensor no-echo flags, sticky until re-measured
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int unsigned N_SENS      = DefNSens,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned TRIG_CYC    = DefTrigCyc,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter int unsigned GAP_CYC     = DefGapCyc,
    parameter int unsigned THR_SHIFT   = DefThrShift,
    // Derived from N_SENS; leave at its default.
    parameter int unsigned SEL_W       = $clog2(N_SENS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [7:0]        thresh,
    input  logic [N_SENS-1:0] echo,
    output logic [N_SENS-1:0] trig,
    output logic [SEL_W-1:0]  sel,
    output logic [CNT_W-1:0]  dist_out,
    output logic [SEL_W-1:0]  dist_id,
    output logic              dist_valid,
    output logic [N_SENS-1:0] obstacle,
    output logic [N_SENS-1:0] fault
);

    localparam logic [CNT_W-1:0] TrigLast    = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYC - 1);
    localparam logic [SEL_W-1:0] SelLast     = SEL_W'(N_SENS - 1);

    sonar_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_SENS-1:0] trig_q, trig_d;
    logic [CNT_W-1:0]  dist_q, dist_d;
    logic [SEL_W-1:0]  id_q, id_d;
    logic              valid_q, valid_d;
    logic [N_SENS-1:0] obs_q, obs_d;
    logic [N_SENS-1:0] fault_q, fault_d;

    logic [N_SENS-1:0] echo_s;
    logic              echo_cur;
    logic [CNT_W+7:0]  thr_ext;
    logic [CNT_W+7:0]  cnt_ext;
    logic              is_near;

    echo_sync #(
        .WIDTH (N_SENS)
    ) u_echo_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (echo),
        .dout (echo_s)
    );

    assign echo_cur = echo_s[sel_q];

    // Compare at CNT_W+8 bits so the shifted threshold never truncates.
    assign thr_ext = {{CNT_W{1'b0}}, thresh} << THR_SHIFT;
    assign cnt_ext = {8'd0, cnt_q};
    assign is_near = (cnt_ext < thr_ext);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        sel_d   = sel_q;
        dist_d  = dist_q;
        id_d    = id_q;
        valid_d = 1'b0;
        obs_d   = obs_q;
        fault_d = fault_q;
        trig_d  = '0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (ena) begin
                    state_d = StTrig;
                end
            end
            StTrig: begin
                if (cnt_q == TrigLast) begin
                    state_d = StWaitRise;
                end
            end
            StWaitRise: begin
                // Echo has priority, so a line already high on entry counts as a rise.
                if (echo_cur) begin
                    state_d = StMeasure;
                end else if (cnt_q >= TimeoutLast) begin
                    state_d        = StGap;
                    dist_d         = '1;
                    id_d           = sel_q;
                    valid_d        = 1'b1;
                    fault_d[sel_q] = 1'b1;
                    obs_d[sel_q]   = 1'b0;
                end
            end
            StMeasure: begin
                if (!echo_cur) begin
                    state_d        = StGap;
                    dist_d         = cnt_q;
                    id_d           = sel_q;
                    valid_d        = 1'b1;
                    fault_d[sel_q] = 1'b0;
                    obs_d[sel_q]   = is_near;
                end else if (cnt_q >= TimeoutLast) begin
                    // Echo still high as the count hits the limit: nothing in range.
                    state_d        = StGap;
                    dist_d         = TimeoutVal;
                    id_d           = sel_q;
                    valid_d        = 1'b1;
                    fault_d[sel_q] = 1'b0;
                    obs_d[sel_q]   = 1'b0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    sel_d   = (sel_q == SelLast) ? '0 : sel_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The counter restarts on every state change; MEASURE starts at 1 because
        // the cycle that saw the rise already counts as echo-high time.
        if (state_d != state_q) begin
            cnt_d = (state_d == StMeasure) ? CNT_W'(1) : '0;
        end

        // sel never changes on the way into TRIG, so sel_q is the target sensor.
        if (state_d == StTrig) begin
            trig_d[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            trig_q  <= '0;
            dist_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            obs_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            trig_q  <= trig_d;
            dist_q  <= dist_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            obs_q   <= obs_d;
            fault_q <= fault_d;
        end
    end

    assign trig       = trig_q;
    assign sel        = sel_q;
    assign dist_out   = dist_q;
    assign dist_id    = id_q;
    assign dist_valid = valid_q;
    assign obstacle   = obs_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler. Stimulus and expected outputs are
// planned up front as per-cycle tables from the timing rules of the scheduler
// (echo delay / width arithmetic), then replayed and compared every cycle.
module tb_sonar_scheduler;
    import sonar_pkg::*;

    localparam int NS    = DefNSens;
    localparam int CW    = DefCntW;
    localparam int TRIG  = 4;
    localparam int TMO   = 200;
    localparam int GAP   = 8;
    localparam int SHIFT = 0;
    localparam int MAXC  = 1160;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic [7:0]    thresh = 8'd50;
    logic [NS-1:0] echo = '0;
    logic [NS-1:0] trig;
    logic [1:0]    sel;
    logic [CW-1:0] dist_out;
    logic [1:0]    dist_id;
    logic          dist_valid;
    logic [NS-1:0] obstacle;
    logic [NS-1:0] fault;

    sonar_scheduler #(
        .N_SENS      (NS),
        .CNT_W       (CW),
        .TRIG_CYC    (TRIG),
        .TIMEOUT_CYC (TMO),
        .GAP_CYC     (GAP),
        .THR_SHIFT   (SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .thresh     (thresh),
        .echo       (echo),
        .trig       (trig),
        .sel        (sel),
        .dist_out   (dist_out),
        .dist_id    (dist_id),
        .dist_valid (dist_valid),
        .obstacle   (obstacle),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Stimulus plan, indexed by cycle (cycle c = interval after the c-th edge).
    logic [NS-1:0] echo_plan [MAXC];
    bit            ena_plan  [MAXC];
    bit            rst_plan  [MAXC];
    logic [7:0]    thr_plan  [MAXC];

    // Expected outputs per cycle.
    logic [NS-1:0] exp_trig  [MAXC];
    logic [1:0]    exp_sel   [MAXC];
    bit            exp_valid [MAXC];
    logic [CW-1:0] exp_dist  [MAXC];
    logic [1:0]    exp_id    [MAXC];
    logic [NS-1:0] exp_obs   [MAXC];
    logic [NS-1:0] exp_fault [MAXC];

    // Model state.
    int            m_sel;
    logic [NS-1:0] m_obs;
    logic [NS-1:0] m_fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Hand-computed pins: cycle, field (0 dist,1 obstacle,2 fault,3 trig,4 sel,5 valid), value.
    int lit_cyc [24] = '{1, 4, 5, 48, 48, 194, 407, 500, 500, 627, 636, 788,
                         800, 810, 858, 891, 900, 900, 970, 1126, 1126, 1127, 1127, 1127};
    int lit_fld [24] = '{3, 3, 3, 0, 5, 0, 0, 1, 2, 0, 3, 0,
                         4, 3, 0, 0, 1, 2, 0, 1, 3, 3, 1, 4};
    int lit_val [24] = '{1, 1, 0, 30, 1, 120, 65535, 1, 4, 200, 1, 49,
                         2, 0, 30, 19, 14, 0, 30, 1, 4, 0, 0, 0};

    // One measurement on the model's current sensor. ts is the idle cycle that
    // samples ena=1; d is the echo start relative to trig falling (may be negative),
    // h the echo width at the pin (0 = no echo). Returns the next idle cycle.
    task automatic meas(input int ts, input int d, input int h, input int thr,
                        output int tnext);
        int            s = m_sel;
        int            e_t = ts + 1;
        int            e_f = e_t + TRIG;
        int            a, w, e_c;
        logic [CW-1:0] dv;
        bit            f, o;
        logic [NS-1:0] one = 1;
        for (int c = e_t; c < e_f; c++) exp_trig[c] = one << s;
        for (int c = ts; c < MAXC; c++) thr_plan[c] = 8'(thr);
        if (h > 0) for (int c = e_f + d; c < e_f + d + h; c++) echo_plan[c][s] = 1'b1;
        a = (d + 2 > 0) ? d + 2 : 0;        // wait-state count when the rise is seen
        w = d + h + 2 - a;                  // echo-high cycles that fall after trig ends
        if (h == 0 || a > TMO - 1) begin
            e_c = e_f + TMO; dv = '1; f = 1'b1; o = 1'b0;
        end else if (w >= TMO) begin
            e_c = e_f + a + TMO; dv = CW'(TMO); f = 1'b0; o = 1'b0;
        end else begin
            e_c = e_f + a + w + 1; dv = CW'(w); f = 1'b0; o = (w < (thr << SHIFT));
        end
        m_obs[s] = o;
        m_fault[s] = f;
        exp_valid[e_c] = 1'b1;
        for (int k = e_c; k < MAXC; k++) begin
            exp_dist[k]  = dv;
            exp_id[k]    = 2'(s);
            exp_obs[k]   = m_obs;
            exp_fault[k] = m_fault;
        end
        m_sel = (s + 1) % NS;
        for (int k = e_c + GAP; k < MAXC; k++) exp_sel[k] = 2'(m_sel);
        tnext = e_c + GAP;
    endtask

    task automatic reset_at(input int c0, input int c1);
        for (int c = c0; c < c1; c++) rst_plan[c] = 1'b1;
        for (int k = c0; k < MAXC; k++) begin
            exp_trig[k] = '0; exp_sel[k] = '0; exp_valid[k] = 1'b0; exp_dist[k] = '0;
            exp_id[k] = '0; exp_obs[k] = '0; exp_fault[k] = '0;
        end
        m_sel = 0; m_obs = '0; m_fault = '0;
    endtask

    task automatic plan();
        int t;
        logic [NS-1:0] one = 1;
        for (int c = 0; c < MAXC; c++) begin
            echo_plan[c] = '0; ena_plan[c] = 1'b1; rst_plan[c] = 1'b0; thr_plan[c] = 8'd50;
            exp_trig[c] = '0; exp_sel[c] = '0; exp_valid[c] = 1'b0; exp_dist[c] = '0;
            exp_id[c] = '0; exp_obs[c] = '0; exp_fault[c] = '0;
        end
        m_sel = 0; m_obs = '0; m_fault = '0;
        t = 0;
        meas(t, 10, 30, 50, t);     // s0 near
        meas(t, 10, 120, 50, t);    // s1 far
        meas(t, 10, 0, 50, t);      // s2 no echo
        meas(t, 5, 300, 50, t);     // s3 stuck high
        meas(t, 20, 50, 50, t);     // s0 exactly at threshold
        meas(t, 10, 49, 50, t);     // s1 just under threshold, ena dropped in MEASURE
        for (int c = t - GAP - 5; c < t + 24; c++) ena_plan[c] = 1'b0;
        t = t + 24;
        meas(t, 0, 30, 50, t);      // s2 re-measured, clears fault
        meas(t, -3, 20, 20, t);     // s3 echo already high on wait entry
        for (int c = t - GAP - 5; c < t + 23; c++) ena_plan[c] = 1'b0;
        reset_at(t + 21, t + 23);
        t = t + 23;
        meas(t, 10, 30, 50, t);     // s0 near
        meas(t, 10, 120, 50, t);    // s1 far
        exp_trig[t + 1] = one << m_sel;
        exp_trig[t + 2] = one << m_sel;
        reset_at(t + 3, t + 5);     // reset two cycles into s2 trigger
        for (int c = t + 3; c < MAXC; c++) ena_plan[c] = 1'b0;
    endtask

    task automatic apply(input int c);
        rst    = rst_plan[c];
        ena    = ena_plan[c];
        echo   = echo_plan[c];
        thresh = thr_plan[c];
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    // Compare process: model tables every cycle plus the literal pins.
    always @(negedge clk) begin
        if (started) begin
            chk("trig", cyc, 32'(trig), 32'(exp_trig[cyc]));
            chk("sel", cyc, 32'(sel), 32'(exp_sel[cyc]));
            chk("dist_valid", cyc, 32'(dist_valid), 32'(exp_valid[cyc]));
            chk("dist_out", cyc, 32'(dist_out), 32'(exp_dist[cyc]));
            chk("dist_id", cyc, 32'(dist_id), 32'(exp_id[cyc]));
            chk("obstacle", cyc, 32'(obstacle), 32'(exp_obs[cyc]));
            chk("fault", cyc, 32'(fault), 32'(exp_fault[cyc]));
            for (int i = 0; i < 24; i++) begin
                if (lit_cyc[i] == cyc) begin
                    case (lit_fld[i])
                        0: chk("lit_dist", cyc, 32'(dist_out), lit_val[i]);
                        1: chk("lit_obstacle", cyc, 32'(obstacle), lit_val[i]);
                        2: chk("lit_fault", cyc, 32'(fault), lit_val[i]);
                        3: chk("lit_trig", cyc, 32'(trig), lit_val[i]);
                        4: chk("lit_sel", cyc, 32'(sel), lit_val[i]);
                        default: chk("lit_valid", cyc, 32'(dist_valid), lit_val[i]);
                    endcase
                end
            end
        end
    end

    initial begin
        plan();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        apply(0);
        started = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            apply(c);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
